// File: rtl/rd_pkg.sv
// rd_pkg: shared tracker encodings, cycle-counter width and saturating increment
package rd_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} trk_state_e;
  localparam int CW = 4;
  localparam logic [CW-1:0] CYC_MAX = '1;
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CYC_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read and push-while-full-with-pop support
module sync_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic         full_o,
  output logic         drop_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic pop_ok, push_ok;
  // Pop only when non-empty; a pop frees the slot a full-FIFO push needs
  always_comb begin
    valid_o = cnt_q != '0;
    full_o = cnt_q == (AW+1)'(DEPTH);
    pop_ok = pop_i & valid_o;
    push_ok = push_i & (~full_o | pop_ok);
    drop_o = push_i & ~push_ok;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    dout_o = mem_q[rd_ptr_q];
  end
  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_ok);
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
      cnt_q <= cnt_d;
    end
  end
  // Storage needs no reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/rd_capture_buf.sv
// rd_capture_buf: times read transactions in rd cycles and buffers {rdata, cycles} on each ds
module rd_capture_buf
  import rd_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          ds,
  input  logic [DW-1:0] rdata,
  input  logic          out_ready,
  input  logic          clr,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_cyc,
  output logic          full,
  output logic          ovf,
  output logic          perr
);
  trk_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, base, cyc_push;
  logic ovf_q, perr_q, perr_set, drop;
  logic [DW+CW-1:0] head;
  // The pushed count includes the ds cycle itself when rd is also high
  always_comb begin
    base = (state_q == ACTIVE) ? cnt_q : '0;
    cyc_push = rd ? sat_inc(base) : base;
    state_d = ds ? IDLE : (rd ? ACTIVE : state_q);
    cnt_d = ds ? '0 : (rd ? sat_inc(base) : cnt_q);
    perr_set = ds & ~rd & (state_q == IDLE);
  end
  // Tracker state, counter and sticky flags; a set beats a same-cycle clr
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ovf_q <= drop | (ovf_q & ~clr);
      perr_q <= perr_set | (perr_q & ~clr);
    end
  end
  sync_fifo #(.W(DW + CW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(ds),
    .pop_i(out_ready),
    .din_i({rdata, cyc_push}),
    .dout_o(head),
    .valid_o(out_valid),
    .full_o(full),
    .drop_o(drop)
  );
  assign out_data = head[DW+CW-1:CW];
  assign out_cyc = head[CW-1:0];
  assign ovf = ovf_q;
  assign perr = perr_q;
endmodule

// File: tb/tb_rd_capture_buf.sv
// tb_rd_capture_buf: directed and random stimulus against a queue-based transaction model
module tb_rd_capture_buf;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0, rd = 1'b0, ds = 1'b0, out_ready = 1'b0, clr = 1'b0;
  logic [7:0] rdata = '0;
  logic out_valid, full, ovf, perr;
  logic [7:0] out_data;
  logic [3:0] out_cyc;
  int checks = 0, failures = 0;
  logic [11:0] mq[$];
  bit mact, movf, mperr;
  int mcnt;

  rd_capture_buf #(.DW(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rd(rd), .ds(ds), .rdata(rdata), .out_ready(out_ready),
    .clr(clr), .out_valid(out_valid), .out_data(out_data), .out_cyc(out_cyc),
    .full(full), .ovf(ovf), .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic d, input logic [7:0] dat,
                      input logic rdy, input logic cl, input logic rs);
    bit pop, accept, ovs, pes;
    int c;
    rd = r; ds = d; rdata = dat; out_ready = rdy; clr = cl; rst = rs;
    ovs = 0; pes = 0;
    if (rs) begin
      mq.delete(); mact = 0; mcnt = 0; movf = 0; mperr = 0;
    end else begin
      pop = (mq.size() != 0) && rdy;
      accept = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      if (d) begin
        c = (mact ? mcnt : 0) + int'(r);
        if (c > 15) c = 15;
        if (accept) mq.push_back({dat, c[3:0]});
        else ovs = 1;
        pes = !mact && !r;
        mact = 0; mcnt = 0;
      end else if (r) begin
        mcnt = (mact ? mcnt : 0) + 1;
        mact = 1;
      end
      movf = ovs || (movf && !cl);
      mperr = pes || (mperr && !cl);
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, mq.size() != 0);
    chk("full", full, mq.size() == DEPTH);
    chk("ovf", ovf, movf);
    chk("perr", perr, mperr);
    if (mq.size() != 0) begin
      chk("out_data", out_data, mq[0][11:4]);
      chk("out_cyc", out_cyc, mq[0][3:0]);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 8'h00, 1, 0, 0);
  endtask

  initial begin
    step(0, 0, 8'h00, 0, 0, 1);
    chk("reset_valid", out_valid, 1'b0);
    step(0, 0, 8'h00, 0, 0, 0);
    // Test 1: three rd cycles then ds
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'hA5, 0, 0, 0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_cyc", out_cyc, 4'd3);
    drain();
    // Test 2: overflow with no consumer
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 8'h00, 0, 0, 0);
      step(0, 1, 8'(i), 0, 0, 0);
      if (i == 4) chk("t2_full", full, 1'b1);
    end
    chk("t2_ovf", ovf, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain", out_data, 8'(i));
      step(0, 0, 8'h00, 1, 0, 0);
    end
    chk("t2_empty", out_valid, 1'b0);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("t2_clr", ovf, 1'b0);
    // Test 3: push while full with a simultaneous pop
    for (int i = 0; i < 4; i++) step(0, 1, 8'h10 + 8'(i), 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h77, 1, 0, 0);
    chk("t3_full", full, 1'b1);
    chk("t3_ovf", ovf, 1'b0);
    chk("t3_head", out_data, 8'h11);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0, 0);
    chk("t3_last", out_data, 8'h77);
    chk("t3_last_cyc", out_cyc, 4'd1);
    drain();
    step(0, 0, 8'h00, 0, 1, 0);
    // Test 4: ds with no prior rd
    step(0, 1, 8'h3C, 0, 0, 0);
    chk("t4_cyc", out_cyc, 4'd0);
    chk("t4_perr", perr, 1'b1);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("t4_clr", perr, 1'b0);
    drain();
    // Same-cycle rd and ds from IDLE counts one cycle without perr
    step(1, 1, 8'h42, 0, 0, 0);
    chk("idle_rdds_cyc", out_cyc, 4'd1);
    chk("idle_rdds_perr", perr, 1'b0);
    drain();
    // Test 5: counter saturation
    for (int i = 0; i < 20; i++) step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h99, 0, 0, 0);
    chk("t5_cyc", out_cyc, 4'd15);
    drain();
    // Test 6: reset mid-transaction with two entries buffered
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h01, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h02, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 1, 8'hEE, 0, 0, 1);
    chk("t6_valid", out_valid, 1'b0);
    step(0, 1, 8'h5A, 0, 0, 0);
    chk("t6_cyc", out_cyc, 4'd0);
    chk("t6_perr", perr, 1'b1);
    // Random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 8'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rd_capture_buf.md
RD_CAPTURE_BUF -- requirements
Module: rd_capture_buf

Interface
REQ-001 SHALL have parameter DW, default 8, meaning read data width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries; power of 2, at least 2.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rd  input  1  read-controller read-phase indicator, high for every cycle the transaction is in progress.
REQ-006 SHALL have port ds  input  1  data-strobe pulse marking transaction completion; rdata valid in that cycle.
REQ-007 SHALL have port rdata  input  DW  memory read data.
REQ-008 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-009 SHALL have port clr  input  1  clears sticky error flags.
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port out_data  output  DW  head-entry data.
REQ-012 SHALL have port out_cyc  output  4  head-entry count of rd-high cycles, saturating at 15.
REQ-013 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-014 SHALL have port ovf  output  1  sticky: a push was dropped.
REQ-015 SHALL have port perr  output  1  sticky: ds arrived with no preceding rd cycle.

Function
REQ-016 SHALL use a 2-state tracker: IDLE and ACTIVE.
REQ-017 IDLE->ACTIVE when rd=1 and ds=0; the cycle counter loads 1.
REQ-018 In ACTIVE, each cycle with rd=1 SHALL increment the cycle counter, saturating at 15.
REQ-019 ds=1 in any state SHALL generate one push of {rdata, counter value}; the tracker returns to IDLE and the counter clears.
REQ-020 ds=1 in IDLE with rd=0 SHALL push with cyc=0 and set perr.
REQ-021 ds=1 and rd=1 in the same IDLE cycle SHALL push with cyc=1; perr is not set.
REQ-022 ACTIVE with rd=0 and ds=0 SHALL hold state and counter (no increment).
REQ-023 A push SHALL be visible at out_valid/out_data/out_cyc the cycle after ds (latency 1).
REQ-024 A pop SHALL occur when out_valid=1 and out_ready=1; the head advances next cycle.
REQ-025 out_data/out_cyc SHALL be read combinationally from the head register; they are don't-care when out_valid=0.
REQ-026 A push while full with a pop in the same cycle SHALL succeed; occupancy is unchanged.
REQ-027 A push while full with no pop SHALL be dropped; FIFO contents are unchanged and ovf is set.
REQ-028 A simultaneous push and pop while empty SHALL only push, because out_valid=0 in that cycle.
REQ-029 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy uses log2(DEPTH)+1 bits.
REQ-030 clr=1 SHALL clear ovf and perr; a set condition in the same cycle wins.

Reset
REQ-031 rst SHALL force: IDLE, counter 0, pointers 0, occupancy 0, out_valid=0, full=0, ovf=0, perr=0.
REQ-032 rst mid-transaction SHALL discard the partial transaction and all FIFO contents; no push occurs in the rst cycle.
REQ-033 FIFO storage registers SHALL NOT require reset.

Structure
REQ-034 Tracker state encodings and the counter width (4) SHALL live in a shared package rd_pkg.
REQ-035 The FIFO SHALL be a sub-module sync_fifo, parameterised on width (DW+4) and DEPTH.

Verification
REQ-036 Test 1 -- rd high 3 cycles, then ds with rdata=0xA5 -> next cycle: out_valid=1, out_data=0xA5, out_cyc=3.
REQ-037 Test 2 -- out_ready=0; 5 transactions (rdata 1..5) -> full=1 after the 4th; 5th dropped; ovf=1; drain yields 1,2,3,4.
REQ-038 Test 3 -- full, and ds coincides with out_ready=1 -> occupancy stays 4; ovf stays 0; the new entry appears last in order.
REQ-039 Test 4 -- ds with no prior rd, rdata=0x3C -> entry cyc=0 and perr=1; clr pulse -> perr=0.
REQ-040 Test 5 -- rd held 20 cycles, then ds -> out_cyc=15 (saturated).
REQ-041 Test 6 -- rst asserted in ACTIVE with 2 entries buffered -> next cycle: out_valid=0, state IDLE; a following ds gives cyc=0 and perr=1.
